dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 183 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32 core: word RAM with byte-lane stores, sized loads and an MMIO page.
// Optional feature macro MISALIGN_TRAP_EN: suppress misaligned accesses and raise sticky misalignErr.
module dmem_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter int unsigned CON_DEPTH = 8,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmemAddr,
    input  logic [31:0] dmemWdata,
    input  logic [2:0]  dmemSize,
    input  logic        dmemWen,
    output logic [31:0] dmemRdata,
    output logic [7:0]  conOutData,
    output logic        conOutValid,
    input  logic        conOutReady,
    output logic        halt,
    output logic [30:0] haltCode,
    output logic        misalignErr
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(CON_DEPTH);

    logic [31:0] mem_q  [MEM_WORDS];
    logic [7:0]  fifo_q [CON_DEPTH];

    logic [PW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic         drop_q, drop_d, halt_q, halt_d;
    logic [30:0]  code_q, code_d;
    logic [63:0]  cycle_q, cycle_d;

    logic        is_b, is_h, is_w, misal;
    logic [31:0] addr;

    assign is_b = (dmemSize[1:0] == 2'b00);
    assign is_h = (dmemSize[1:0] == 2'b01);
    assign is_w = dmemSize[1];

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign misal = (is_h & dmemAddr[0]) | (is_w & (dmemAddr[1:0] != 2'b00));
    assign addr  = dmemAddr;
`else
    // Misaligned halves/words are silently forced onto their natural boundary.
    assign misal = 1'b0;
    assign addr  = {dmemAddr[31:2], dmemAddr[1] & ~is_w, dmemAddr[0] & is_b};
`endif

    logic          in_ram, in_mmio;
    logic [1:0]    reg_sel;
    logic [AW-1:0] widx;

    assign in_ram  = (addr[31:AW+2] == '0);
    assign in_mmio = (addr[31:4] == MMIO_BASE[31:4]);
    assign reg_sel = addr[3:2];
    assign widx    = addr[AW+1:2];

    logic [PW:0] count;
    logic        empty, full, we, push, pop, accept;

    assign count  = wr_ptr_q - rd_ptr_q;
    assign empty  = (count == '0);
    assign full   = (count == (PW+1)'(CON_DEPTH));
    assign we     = dmemWen & ~rst & ~misal;
    assign push   = we & in_mmio & (reg_sel == 2'd0);
    assign pop    = ~empty & conOutReady;
    assign accept = push & (~full | pop);

    // Zero-latency load path with lane select and extension.
    logic [31:0] word_rd;
    logic [15:0] half_rd;
    logic [7:0]  byte_rd;

    assign word_rd = mem_q[widx];
    assign byte_rd = 8'(word_rd >> {addr[1:0], 3'b000});
    assign half_rd = 16'(word_rd >> {addr[1], 4'b0000});

    always_comb begin
        dmemRdata = '0;
        if (misal) begin
            dmemRdata = '0;
        end else if (in_ram) begin
            if (is_b)      dmemRdata = {{24{byte_rd[7] & ~dmemSize[2]}}, byte_rd};
            else if (is_h) dmemRdata = {{16{half_rd[15] & ~dmemSize[2]}}, half_rd};
            else           dmemRdata = word_rd;
        end else if (in_mmio) begin
            case (reg_sel)
                2'd0:    dmemRdata = {29'b0, drop_q, full, empty};
                2'd1:    dmemRdata = {code_q, halt_q};
                2'd2:    dmemRdata = cycle_q[31:0];
                default: dmemRdata = cycle_q[63:32];
            endcase
        end
    end

    // Control-register next state: FIFO pointers, drop, TOHOST, cycle counter.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        drop_d   = drop_q;
        halt_d   = halt_q;
        code_d   = code_q;
        cycle_d  = halt_q ? cycle_q : cycle_q + 64'd1;
        if (accept)              wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        if (pop)                 rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        if (push & full & ~pop)  drop_d   = 1'b1;
        if (we & in_mmio & (reg_sel == 2'd1) & ~halt_q) begin
            halt_d = 1'b1;
            code_d = dmemWdata[0] ? dmemWdata[31:1] : 31'd0;
        end
`ifdef MISALIGN_TRAP_EN
        misalign_d = misalign_q | misal;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= 1'b0;
            halt_q   <= 1'b0;
            code_q   <= '0;
            cycle_q  <= '0;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
            halt_q   <= halt_d;
            code_q   <= code_d;
            cycle_q  <= cycle_d;
`ifdef MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Byte enables and lane-replicated store data.
    logic        ram_we;
    logic [3:0]  be;
    logic [31:0] wd;

    assign ram_we = we & in_ram;

    always_comb begin
        be = 4'hF;
        wd = dmemWdata;
        if (is_b) begin
            be = 4'b0001 << addr[1:0];
            wd = {4{dmemWdata[7:0]}};
        end else if (is_h) begin
            be = 4'b0011 << {addr[1], 1'b0};
            wd = {2{dmemWdata[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[widx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) fifo_q[wr_ptr_q[PW-1:0]] <= dmemWdata[7:0];
    end

    assign conOutValid = ~empty;
    assign conOutData  = empty ? 8'h00 : fifo_q[rd_ptr_q[PW-1:0]];
    assign halt        = halt_q;
    assign haltCode    = code_q;
`ifdef MISALIGN_TRAP_EN
    assign misalignErr = misalign_q;
`else
    assign misalignErr = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table, directed corner sequences, randomized model checks.
module tb_dmem_responder;
    localparam logic [31:0] MB = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmemAddr, dmemWdata, dmemRdata;
    logic [2:0]  dmemSize;
    logic        dmemWen, conOutValid, conOutReady, halt, misalignErr;
    logic [7:0]  conOutData;
    logic [30:0] haltCode;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk(clk), .rst(rst), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata),
        .dmemSize(dmemSize), .dmemWen(dmemWen), .dmemRdata(dmemRdata),
        .conOutData(conOutData), .conOutValid(conOutValid), .conOutReady(conOutReady),
        .halt(halt), .haltCode(haltCode), .misalignErr(misalignErr)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] mref [16384];
    logic [7:0] cq [$];
    bit         mdrop;

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic [2:0]  s;
        logic [31:0] exp;
    } vec_t;
    localparam int NV = 18;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] s);
        if (s[1:0] == 2'b00) return 1;
        if (s[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a, input logic [2:0] s);
        return a & ~32'(nbytes(s) - 1);
    endfunction

    function automatic bit is_misaligned(input logic [31:0] a, input logic [2:0] s);
        return (a & 32'(nbytes(s) - 1)) != 32'd0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] s);
        logic [31:0] ea, v;
        int n;
        n = nbytes(s);
`ifdef MISALIGN_TRAP_EN
        if (is_misaligned(a, s)) return 32'd0;
`endif
        ea = align(a, s);
        if (ea >= 32'h4000) return 32'd0;
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mref[ea + 32'(i)]) << (8 * i));
        if (!s[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!s[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        dmemWen = 1'b0;
        conOutReady = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cq.delete();
        mdrop = 1'b0;
    endtask

    task automatic store_ram(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        logic [31:0] ea;
        dmemAddr = a; dmemWdata = d; dmemSize = s; dmemWen = 1'b1;
        @(posedge clk);
        #1;
        dmemWen = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (is_misaligned(a, s)) return;
`endif
        ea = align(a, s);
        if (ea < 32'h4000)
            for (int i = 0; i < nbytes(s); i++) mref[ea + 32'(i)] = 8'(d >> (8 * i));
    endtask

    task automatic load_chk(input string nm, input logic [31:0] a, input logic [2:0] s);
        dmemAddr = a; dmemSize = s; dmemWen = 1'b0;
        #1;
        chk(nm, dmemRdata, model_load(a, s));
    endtask

    task automatic mmio_wr(input logic [3:0] off, input logic [31:0] d);
        dmemAddr = MB | 32'(off); dmemSize = 3'b010; dmemWdata = d; dmemWen = 1'b1;
        @(posedge clk);
        #1;
        dmemWen = 1'b0;
    endtask

    task automatic mmio_rd(input string nm, input logic [3:0] off, input logic [31:0] exp);
        dmemAddr = MB | 32'(off); dmemSize = 3'b010; dmemWen = 1'b0;
        #1;
        chk(nm, dmemRdata, exp);
    endtask

    function automatic logic [31:0] con_status();
        return {29'b0, mdrop, cq.size() == 8, cq.size() == 0};
    endfunction

    // One console cycle: optional push, consumer ready; head is checked before the edge.
    task automatic con_cycle(input bit psh, input logic [7:0] b, input bit rdy);
        dmemAddr = MB; dmemSize = 3'b010; dmemWdata = 32'(b); dmemWen = psh; conOutReady = rdy;
        #1;
        chk("con_valid", 32'(conOutValid), 32'(cq.size() != 0));
        chk("con_data", 32'(conOutData), (cq.size() != 0) ? 32'(cq[0]) : 32'd0);
        @(posedge clk);
        if (rdy && cq.size() != 0) void'(cq.pop_front());
        if (psh) begin
            if (cq.size() < 8) cq.push_back(b);
            else mdrop = 1'b1;
        end
        #1;
        dmemWen = 1'b0;
        conOutReady = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  s;

        tbl[0]  = '{"lb_103",    32'h103, 3'b000, 32'hFFFF_FFDE};
        tbl[1]  = '{"lbu_103",   32'h103, 3'b100, 32'h0000_00DE};
        tbl[2]  = '{"lh_102",    32'h102, 3'b001, 32'hFFFF_DEAD};
        tbl[3]  = '{"lhu_102",   32'h102, 3'b101, 32'h0000_DEAD};
        tbl[4]  = '{"lw_100",    32'h100, 3'b010, 32'hDEAD_BEEF};
        tbl[5]  = '{"lb_100",    32'h100, 3'b000, 32'hFFFF_FFEF};
        tbl[6]  = '{"lhu_100",   32'h100, 3'b101, 32'h0000_BEEF};
        tbl[7]  = '{"lw_sz7",    32'h100, 3'b111, 32'hDEAD_BEEF};
        tbl[8]  = '{"lw_0",      32'h000, 3'b010, 32'h0102_0304};
        tbl[9]  = '{"lw_top",    32'h3FFC, 3'b010, 32'hA5A5_5A5A};
        tbl[10] = '{"lb_top",    32'h3FFF, 3'b000, 32'hFFFF_FFA5};
        tbl[11] = '{"past_ram",  32'h4000, 3'b010, 32'h0};
        tbl[12] = '{"unmapped",  32'h8000_0000, 3'b010, 32'h0};
`ifdef MISALIGN_TRAP_EN
        tbl[13] = '{"lh_odd",    32'h103, 3'b001, 32'h0};
        tbl[14] = '{"lw_odd",    32'h101, 3'b010, 32'h0};
`else
        tbl[13] = '{"lh_odd",    32'h103, 3'b001, 32'hFFFF_DEAD};
        tbl[14] = '{"lw_odd",    32'h101, 3'b010, 32'hDEAD_BEEF};
`endif
        tbl[15] = '{"mmio_stat", MB | 32'h1, 3'b000, 32'h1};
        tbl[16] = '{"cycle_hi",  MB | 32'hC, 3'b000, 32'h0};
        tbl[17] = '{"mmio_hole", MB | 32'h10, 3'b010, 32'h0};

        dmemAddr = '0; dmemWdata = '0; dmemSize = 3'b010; dmemWen = 1'b0; conOutReady = 1'b0;
        do_reset();

        chk("rst_valid", 32'(conOutValid), 32'd0);
        chk("rst_data", 32'(conOutData), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_code", 32'(haltCode), 32'd0);
        chk("rst_misalign", 32'(misalignErr), 32'd0);
        mmio_rd("rst_cycle", 4'h8, 32'd0);
        repeat (7) @(posedge clk);
        #1;
        mmio_rd("cycle_7", 4'h8, 32'd7);

        store_ram(32'h100, 32'hDEAD_BEEF, 3'b010);
        store_ram(32'h000, 32'h0102_0304, 3'b010);
        store_ram(32'h3FFC, 32'hA5A5_5A5A, 3'b010);
        store_ram(32'h4000, 32'hFFFF_FFFF, 3'b010);
        for (int i = 0; i < NV; i++) begin
            dmemAddr = tbl[i].a; dmemSize = tbl[i].s; dmemWen = 1'b0;
            #1;
            chk(tbl[i].nm, dmemRdata, tbl[i].exp);
        end

        // Store-then-load ordering: old data during the write cycle, new data after.
        store_ram(32'h100, 32'h1122_3344, 3'b010);
        dmemAddr = 32'h101; dmemSize = 3'b000; dmemWdata = 32'h5A; dmemWen = 1'b1;
        #1;
        chk("sb_same_cycle", dmemRdata, 32'h0000_0033);
        @(posedge clk);
        #1;
        dmemWen = 1'b0;
        mref[32'h101] = 8'h5A;
        load_chk("sb_after", 32'h100, 3'b010);
        chk("sb_word", dmemRdata, 32'h1122_5A44);
        store_ram(32'h104, 32'h0, 3'b010);
        dmemAddr = 32'h104; dmemSize = 3'b010; dmemWdata = 32'hCAFE_F00D; dmemWen = 1'b1;
        #1;
        chk("sw_same_cycle", dmemRdata, 32'h0);
        @(posedge clk);
        #1;
        dmemWen = 1'b0;
        chk("sw_after", dmemRdata, 32'hCAFE_F00D);

        for (int i = 0; i < 64; i++) store_ram(32'h300 + 32'(4 * i), $urandom, 3'b010);
        for (int i = 0; i < 400; i++) begin
            a = 32'h300 + 32'($urandom_range(0, 255));
            s = 3'($urandom_range(0, 7));
`ifdef MISALIGN_TRAP_EN
            a = align(a, s);
`endif
            if ($urandom_range(0, 1) == 1) store_ram(a, $urandom, s);
            else load_chk("rand_ld", a, s);
        end

        // A store and a push in the reset cycle must both be lost.
        store_ram(32'h120, 32'h0, 3'b010);
        rst = 1'b1;
        dmemAddr = 32'h120; dmemSize = 3'b010; dmemWdata = 32'h55; dmemWen = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; dmemWen = 1'b0;
        load_chk("rst_store", 32'h120, 3'b010);

        for (int i = 1; i <= 9; i++) con_cycle(1'b1, 8'(i), 1'b0);
        mmio_rd("con_full_drop", 4'h0, con_status());
        chk("con_status6", con_status(), 32'h6);
        for (int i = 0; i < 8; i++) con_cycle(1'b0, 8'h00, 1'b1);
        mmio_rd("con_drained", 4'h0, con_status());
        chk("con_empty_valid", 32'(conOutValid), 32'd0);

        do_reset();
        for (int i = 0; i < 8; i++) con_cycle(1'b1, 8'h10 + 8'(i), 1'b0);
        con_cycle(1'b1, 8'h41, 1'b1);
        mmio_rd("con_push_pop", 4'h0, 32'h2);
        for (int i = 0; i < 8; i++) con_cycle(1'b0, 8'h00, 1'b1);
        mmio_rd("con_push_pop_end", 4'h0, 32'h1);

        for (int i = 0; i < 3; i++) con_cycle(1'b1, 8'hE0 + 8'(i), 1'b0);
        do_reset();
        #1;
        chk("rst_discard", 32'(conOutValid), 32'd0);
        for (int i = 0; i < 150; i++)
            con_cycle(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) == 0);
        mmio_rd("con_rand_stat", 4'h0, con_status());

        do_reset();
        mmio_wr(4'h4, 32'h7);
        chk("halt_set", 32'(halt), 32'd1);
        chk("halt_code", 32'(haltCode), 32'd3);
        mmio_rd("tohost_rd", 4'h4, 32'h7);
        mmio_rd("cycle_at_halt", 4'h8, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        mmio_rd("cycle_frozen", 4'h8, 32'd1);
        mmio_wr(4'h4, 32'h0);
        chk("halt_sticky_code", 32'(haltCode), 32'd3);
        mmio_wr(4'h8, 32'h1234);
        mmio_rd("cycle_ro", 4'h8, 32'd1);
        do_reset();
        chk("halt_cleared", 32'(halt), 32'd0);
        mmio_rd("cycle_cleared", 4'h8, 32'd0);
        mmio_wr(4'h4, 32'h10);
        chk("halt_even", 32'(halt), 32'd1);
        chk("halt_even_code", 32'(haltCode), 32'd0);
        do_reset();

        store_ram(32'h200, 32'h1234_5678, 3'b010);
        store_ram(32'h202, 32'hFFFF_FFFF, 3'b010);
`ifdef MISALIGN_TRAP_EN
        load_chk("sw_misal_ram", 32'h200, 3'b010);
        chk("sw_misal_const", dmemRdata, 32'h1234_5678);
        load_chk("lw_misal", 32'h202, 3'b010);
        chk("misalign_err", 32'(misalignErr), 32'd1);
`else
        load_chk("sw_misal_ram", 32'h200, 3'b010);
        chk("sw_misal_const", dmemRdata, 32'hFFFF_FFFF);
        chk("misalign_err", 32'(misalignErr), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
